// File: rtl/decode_pkg.sv
// Shared types and constants for the decode scheduler.
package decode_pkg;

  localparam int CODE_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    HOLD   = 2'd2
  } state_e;

endpackage

// File: rtl/decoder.sv
// Existing 4-bit decoder datapath: Gray code in, binary out. Shared by decode_sched.
module decoder (
  input  logic [3:0] C,
  output logic [3:0] y
);

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    y[3] = C[3];
    y[2] = C[3] ^ C[2];
    y[1] = C[3] ^ C[2] ^ C[1];
    y[0] = C[3] ^ C[2] ^ C[1] ^ C[0];
  end

endmodule

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin picker: first set request at or above ptr, wrapping.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       any
);

  logic       found;
  logic [1:0] idx;

  // Walk the four slots starting at ptr; the 2-bit index wraps 3 -> 0 naturally.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = ptr;
    any    = |req;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        found       = 1'b1;
        gnt[idx]    = 1'b1;
        gnt_id      = idx;
      end
    end
  end

endmodule

// File: rtl/decode_sched.sv
// Round-robin scheduler sharing one decoder among four requesters.
// Grant in IDLE, decode from the registered code, hold the result until consumed.
module decode_sched
  import decode_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [4*NREQ-1:0]    req_code,
  output logic [NREQ-1:0]      req_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CODE_W-1:0]    out_y,
  output logic [IDW-1:0]       out_id,
  output logic                 busy,
  output logic [CNTW-1:0]      served_cnt
);

  state_e              state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [IDW-1:0]      id_q, id_d;
  logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
  logic                out_valid_q, out_valid_d;
  logic [CODE_W-1:0]   out_y_q, out_y_d;
  logic [IDW-1:0]      out_id_q, out_id_d;
  logic [CNTW-1:0]     served_cnt_q, served_cnt_d;

  logic [3:0]          pick_gnt;
  logic [1:0]          pick_id;
  logic                pick_any;
  logic [CODE_W-1:0]   dec_y;

  rr_pick4 u_pick (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .gnt    (pick_gnt),
    .gnt_id (pick_id),
    .any    (pick_any)
  );

  // The decoder only ever sees the registered code, never a requester directly.
  decoder u_dec (
    .C (code_q),
    .y (dec_y)
  );

  // Next-state and grant logic; requests are only looked at in IDLE.
  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    id_d         = id_q;
    rr_ptr_d     = rr_ptr_q;
    out_valid_d  = out_valid_q;
    out_y_d      = out_y_q;
    out_id_d     = out_id_q;
    served_cnt_d = served_cnt_q;
    req_ready    = '0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          req_ready = pick_gnt;
          code_d    = req_code[{pick_id, 2'b00} +: CODE_W];
          id_d      = pick_id;
          state_d   = DECODE;
        end
      end
      DECODE: begin
        out_y_d     = dec_y;
        out_id_d    = id_q;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        // Pointer moves past the served requester only once its result is taken.
        if (out_ready) begin
          out_valid_d  = 1'b0;
          rr_ptr_d     = id_q + 2'd1;
          served_cnt_d = served_cnt_q + 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset discards any in-flight result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      code_q       <= '0;
      id_q         <= '0;
      rr_ptr_q     <= '0;
      out_valid_q  <= 1'b0;
      out_y_q      <= '0;
      out_id_q     <= '0;
      served_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      id_q         <= id_d;
      rr_ptr_q     <= rr_ptr_d;
      out_valid_q  <= out_valid_d;
      out_y_q      <= out_y_d;
      out_id_q     <= out_id_d;
      served_cnt_q <= served_cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_y      = out_y_q;
  assign out_id     = out_id_q;
  assign served_cnt = served_cnt_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_decode_sched.sv
// Directed bench for decode_sched; a second instance with a 4-bit counter covers wrap.
module tb_decode_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [15:0] req_code  = '0;
  logic        out_ready = 1'b0;

  logic [3:0]  req_ready,  req_ready4;
  logic        out_valid,  out_valid4;
  logic [3:0]  out_y,      out_y4;
  logic [1:0]  out_id,     out_id4;
  logic        busy,       busy4;
  logic [15:0] served_cnt;
  logic [3:0]  served_cnt4;

  logic [3:0]  ref_code = '0;
  logic [3:0]  ref_y;

  int checks = 0;
  int errors = 0;

  logic [3:0] held_y;
  logic [1:0] held_id;

  always #5 clk = ~clk;

  decode_sched #(.NREQ(4), .IDW(2), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_code(req_code),
    .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_id(out_id), .busy(busy), .served_cnt(served_cnt)
  );

  decode_sched #(.NREQ(4), .IDW(2), .CNTW(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_code(req_code),
    .req_ready(req_ready4), .out_valid(out_valid4), .out_ready(out_ready),
    .out_y(out_y4), .out_id(out_id4), .busy(busy4), .served_cnt(served_cnt4)
  );

  decoder u_ref (.C(ref_code), .y(ref_y));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 2-3 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    // Reset check
    do_reset();
    #1;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_y", 32'(out_y), 0);
    chk("rst_out_id", 32'(out_id), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_served", 32'(served_cnt), 0);
    chk("rst_served4", 32'(served_cnt4), 0);

    // Single request: requester 2, code 1101
    req_code  = 16'h0D00;
    req_valid = 4'b0100;
    out_ready = 1'b1;
    ref_code  = 4'b1101;
    #1;
    chk("single_grant", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    #1;
    chk("single_c1_ready", 32'(req_ready), 0);
    chk("single_c1_busy", 32'(busy), 1);
    chk("single_c1_valid", 32'(out_valid), 0);
    tick(); #1;
    chk("single_c2_valid", 32'(out_valid), 1);
    chk("single_c2_id", 32'(out_id), 2);
    chk("single_c2_y_ref", 32'(out_y), 32'(ref_y));
    chk("single_c2_y_const", 32'(out_y), 32'h9);
    tick(); #1;
    chk("single_done_valid", 32'(out_valid), 0);
    chk("single_done_busy", 32'(busy), 0);
    chk("single_served", 32'(served_cnt), 1);

    // Fairness: all valid from pointer 0
    do_reset();
    req_code  = {4'b0101, 4'b0100, 4'b0011, 4'b0010};
    req_valid = 4'b1111;
    out_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      ref_code = 4'(t % 4) + 4'd2;
      #1;
      chk($sformatf("fair%0d_grant", t), 32'(req_ready), 32'(1 << (t % 4)));
      tick(); tick(); #1;
      chk($sformatf("fair%0d_valid", t), 32'(out_valid), 1);
      chk($sformatf("fair%0d_id", t), 32'(out_id), 32'(t % 4));
      chk($sformatf("fair%0d_y", t), 32'(out_y), 32'(ref_y));
      tick();
    end
    #1;
    chk("fair_served", 32'(served_cnt), 5);

    // Backpressure: requester 0 alone (pointer is 1), then hold for 10 cycles
    req_valid = 4'b0001;
    out_ready = 1'b0;
    ref_code  = 4'b0010;
    #1;
    chk("bp_grant", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    tick(); #1;
    chk("bp_valid_rise", 32'(out_valid), 1);
    chk("bp_y", 32'(out_y), 32'(ref_y));
    held_y  = out_y;
    held_id = out_id;
    req_valid = 4'b1111;
    for (int t = 0; t < 10; t++) begin
      tick(); #1;
      chk($sformatf("bp%0d_valid", t), 32'(out_valid), 1);
      chk($sformatf("bp%0d_y", t), 32'(out_y), 32'(held_y));
      chk($sformatf("bp%0d_id", t), 32'(out_id), 32'(held_id));
      chk($sformatf("bp%0d_ready", t), 32'(req_ready), 0);
    end
    chk("bp_held_id", 32'(held_id), 0);
    out_ready = 1'b1;
    tick(); #1;
    chk("bp_done_valid", 32'(out_valid), 0);
    chk("bp_served", 32'(served_cnt), 6);
    // Pointer moved to 1 after serving requester 0
    chk("bp_next_grant", 32'(req_ready), 32'h2);
    req_valid = '0;
    #1;

    // Reset mid-HOLD: requester 0 in HOLD, pointer is 1 beforehand
    req_valid = 4'b0001;
    out_ready = 1'b0;
    #1;
    chk("mr_grant", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    tick(); #1;
    chk("mr_hold_valid", 32'(out_valid), 1);
    rst = 1'b1;
    #1;
    chk("mr_async_valid", 32'(out_valid), 0);
    chk("mr_async_served", 32'(served_cnt), 0);
    chk("mr_async_busy", 32'(busy), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    req_valid = 4'b1111;
    #1;
    chk("mr_ptr_zero_grant", 32'(req_ready), 32'h1);

    // Counter wrap: 17 back-to-back transactions, rotating through all requesters
    out_ready = 1'b1;
    for (int t = 0; t < 17; t++) begin
      tick(); tick(); #1;
      if (t % 4 == 0) chk($sformatf("wrap%0d_id", t), 32'(out_id), 32'(t % 4));
      tick();
    end
    req_valid = '0;
    #1;
    chk("wrap_served16", 32'(served_cnt), 17);
    chk("wrap_served4", 32'(served_cnt4), 1);
    chk("wrap_idle", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
